add32_seq_ctrl: RTL
===================

ADD32_SEQ_CTRL -- requirements
Module: add32_seq_ctrl

Interface
REQ-001 Parameter: none; operand width fixed at 32 bits, processed as four 8-bit slices.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-005 in_valid  in  1  request operands present.
REQ-006 in_ready  out  1  block can accept a request (registered).
REQ-007 a  in  32  operand A.
REQ-008 b  in  32  operand B.
REQ-009 sub  in  1  1 = compute a-b, 0 = compute a+b+cin.
REQ-010 cin  in  1  carry-in for add; ignored when sub=1.
REQ-011 out_valid  out  1  result valid (registered).
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 s  out  32  sum/difference.
REQ-014 cout  out  1  carry out of bit 31 (sub: 1 = no borrow).
REQ-015 ovf  out  1  two's-complement signed overflow.
REQ-016 zero  out  1  s == 0.

Function
REQ-017 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-018 Request accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in IDLE.
REQ-019 On accept: latch A=a, B'=(sub ? ~b : b), carry=(sub ? 1 : cin), beat counter=0, clear s/cout/ovf/zero, go CALC.
REQ-020 Datapath SHALL contain exactly one 8-bit carry-lookahead adder slice (generate/propagate, full lookahead carries), shared across beats; no 32-bit adder.
REQ-021 CALC beat k (k=0..3): slice adds A[8k+7:8k], B'[8k+7:8k], carry; writes s[8k+7:8k]; carry register <= slice carry-out; counter increments.
REQ-022 After beat 3: cout <= final carry; ovf <= (A[31]==B'[31]) && (s[31]!=A[31]); zero <= (s==0); out_valid <= 1; go DONE.
REQ-023 Latency: accept at edge T -> out_valid=1 after edge T+4; s, cout, ovf, zero valid and stable whenever out_valid=1.
REQ-024 DONE: outputs held; on edge with out_ready=1: out_valid <= 0, in_ready <= 1, go IDLE. Next accept possible no earlier than the following edge.
REQ-025 out_ready=1 in IDLE/CALC SHALL have no effect; in_valid in CALC/DONE SHALL be ignored (no capture, no queuing).
REQ-026 Counter SHALL be 2 bits; wraps 3->0 only on CALC->DONE transition.
REQ-027 Operand inputs SHALL be sampled only at accept; changes afterward do not affect the result.

Reset
REQ-028 While rst_n=0 at a rising edge: state IDLE, in_ready=0, out_valid=0, s=0, cout=0, ovf=0, zero=0, counter=0, carry=0.
REQ-029 First rising edge with rst_n=1 SHALL set in_ready=1.
REQ-030 Reset asserted mid-CALC or DONE SHALL abort the operation; no out_valid for it is ever produced.

Verification
REQ-031 a=0x000000FF, b=0x00000001, sub=0, cin=0 -> s=0x00000100, cout=0, ovf=0, zero=0, out_valid exactly 4 edges after accept.
REQ-032 a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0 -> s=0x00000000, cout=1, ovf=0, zero=1; and a=0x7FFFFFFF, b=0, cin=1 -> s=0x80000000, ovf=1, cout=0.
REQ-033 sub=1: a=5, b=7 -> s=0xFFFFFFFE, cout=0, ovf=0; a=0x80000000, b=1 -> s=0x7FFFFFFF, cout=1, ovf=1; cin toggled has no effect.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> s/flags stable, in_ready=0, no capture; out_ready=1 -> IDLE next edge.
REQ-035 rst_n=0 for one edge during beat 2 -> all outputs zero next edge, no out_valid; fresh request then completes correctly.
REQ-036 Random regression: 10k requests with random in_valid/out_ready gaps -> every result equals reference 32-bit add/sub with correct cout/ovf/zero, one result per accept, in order.

Source files
------------

// File: rtl/add32_seq_ctrl.sv
// Sequential 32-bit adder/subtractor: one shared 8-bit carry-lookahead slice,
// four beats per request, valid/ready handshake on both sides.
module add32_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s,
  output logic        cout,
  output logic        ovf,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic        cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic        accept;
  logic [4:0]  base;
  logic [7:0]  sl_a, sl_b, sl_g, sl_p, sl_sum;
  logic [8:0]  sl_c;

  assign accept = (state_q == IDLE) && in_valid && in_ready_q;
  assign base   = {cnt_q, 3'b000};
  assign sl_a   = a_q[base +: 8];
  assign sl_b   = b_q[base +: 8];

  // Each carry is a flat sum-of-products of g/p terms, not a rippled chain.
  always_comb begin
    logic acc;
    logic term;
    acc     = 1'b0;
    term    = 1'b0;
    sl_g    = sl_a & sl_b;
    sl_p    = sl_a ^ sl_b;
    sl_c    = '0;
    sl_c[0] = carry_q;
    for (int unsigned i = 0; i < 8; i++) begin
      acc = carry_q;
      for (int unsigned j = 0; j <= i; j++) acc = acc & sl_p[j];
      for (int unsigned j = 0; j <= i; j++) begin
        term = sl_g[j];
        for (int unsigned k = j + 1; k <= i; k++) term = term & sl_p[k];
        acc = acc | term;
      end
      sl_c[i+1] = acc;
    end
    sl_sum = sl_p ^ sl_c[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = sub | cin;
          cnt_d      = '0;
          s_d        = '0;
          cout_d     = 1'b0;
          ovf_d      = 1'b0;
          zero_d     = 1'b0;
          in_ready_d = 1'b0;
        end
      end
      CALC: begin
        s_d[base +: 8] = sl_sum;
        carry_d        = sl_c[8];
        cnt_d          = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cout_d      = sl_c[8];
          ovf_d       = (a_q[31] == b_q[31]) && (s_d[31] != a_q[31]);
          zero_d      = (s_d == '0);
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
